vertex_update: RTL and testbench
================================

# vertex_update

Even-vertex (original-vertex) repositioning stage of the Loop subdivision pipeline, directly downstream of the `neighbor` builder. Once the neighbour lists are complete, it walks every original vertex, reads its neighbour list and the neighbour positions, and applies the Loop rule `v' = v + beta(n)·(Σnbr − n·v)`. Results are written to a dedicated output RAM. Coordinates are signed Q16.16 in 32-bit words.

## Interface
- MAX_NEIGHBOR_COUNT, 10, neighbour-list stride in NBR RAM. Legal range 3..15.
- ADDR_WIDTH, 9, address width of all three RAMs.

- clk  in  1  clock. All state and outputs update on the falling edge; RAMs sample on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin a pass. Sampled in IDLE only.
- vertex_count  in  32  number of original vertices. Latched on accepted start.
- RAM_OBJ_Do  in  32  OBJ read data.
- RAM_NBR_Do  in  32  NBR read data.
- RAM_OBJ_EN, RAM_NBR_EN, RAM_OUT_EN  out  1  RAM enables.
- RAM_OBJ_A, RAM_NBR_A, RAM_OUT_A  out  ADDR_WIDTH  addresses.
- RAM_OBJ_WE, RAM_NBR_WE, RAM_OUT_WE  out  4  byte write enables. OBJ and NBR WE are always 0.
- RAM_OBJ_Di, RAM_NBR_Di  out  32  always 0.
- RAM_OUT_Di  out  32  output coordinate.
- busy  out  1  high from the negedge after start until the pass finishes.

## Operation
- **Memory map** (vertex v is 1-based, k = v−1):
  - Position of v: OBJ addresses 2+3k+{0,1,2} (x, y, z).
  - Neighbour count: NBR address k·MAX.
  - Neighbour indices: NBR addresses k·MAX+1 .. k·MAX+n.
  - Output: OUT addresses 3k+{0,1,2}.
- **Neighbour count n**: taken from `RAM_NBR_Do[3:0]`. If n > MAX_NEIGHBOR_COUNT, n is clamped to MAX_NEIGHBOR_COUNT.
- **beta LUT** (Q0.16, floor), indexed by n:
  - n = 0..8: 0, 0, 8192, 12288, 6144, 4915, 4096, 3510, 3072
  - n = 9..15: 2730, 2457, 2234, 2048, 1890, 1755, 1638
- **Arithmetic** (per axis c):
  - Accumulator `sum_c` is 40-bit signed, sign-extended, cleared per vertex.
  - `diff_c = sum_c − n·self_c`, 40-bit signed.
  - `prod = diff_c · beta`, signed × unsigned-17.
  - `out_c = self_c + prod[47:16]`, arithmetic shift, wrapping 32-bit add, no saturation.
- **State machine**:
  - IDLE → on start: if vertex_count = 0 go to DONE, else go to RD_CNT.
  - RD_CNT → RD_IDX if n > 0, else RD_SELF.
  - RD_IDX → RD_NPOS (x, y, z). RD_NPOS loops back to RD_IDX until all n neighbours are read, then goes to RD_SELF (x, y, z).
  - RD_SELF → COMPUTE → WRITE (x, y, z) → NEXT.
  - NEXT → RD_CNT for the next vertex, or DONE after the last vertex.
  - DONE → IDLE, deasserting busy.
- **Read protocol**: every RAM read costs 2 negedges. The address is driven on the first; `Do` is captured on the second.
- **Write protocol**: one word per negedge with RAM_OUT_WE = 4'b1111. WE returns to 0 in NEXT.
- **Neighbour index 0** (corrupt list): reads of that neighbour's position are skipped and the neighbour contributes self to the sum, so its diff contribution is 0.

## Timing
- **Reset values**: state IDLE, busy 0, all EN 0, all WE 0, all A 0, all Di 0. Reset takes effect immediately regardless of clock edge.
- **Reset mid-pass**: aborts the pass at once. No further writes occur, and OUT contents are undefined for vertices not yet written.
- **Start**:
  - busy rises on the same negedge that samples start.
  - start is ignored while busy.
  - EN rises with busy and falls in DONE.
- **Per-vertex latency**: exactly 13 + 8n negedges. Breakdown: count 2, each neighbour 8, self 6, compute 1, write 3, next 1.
- **Pass latency**: Σ(13 + 8nᵢ) + 2 (IDLE and DONE).
- **vertex_count = 0**: busy is high for exactly 1 cycle and nothing is written.
- **n = 0 or 1**: beta = 0, so out = self, with the same cycle count as any other vertex.

## Test plan
- **n = 4**: self x = 0x00010000, four neighbours with x = 0x00020000 → OUT x = 0x00016000. Vertex takes 45 cycles.
- **n = 3**: self x = 0, neighbour x = 1.0, 2.0, 3.0 → OUT x = 0x00012000.
- **Negative coordinate, n = 6**: self x = 0xFFFF0000, all six neighbours x = 0 → OUT x = 0xFFFF6000.
- **Isolated vertex and empty pass**:
  - n = 0 with self (5, 6, 7) → OUT (5, 6, 7) after 13 cycles.
  - vertex_count = 0 → busy high for one cycle and no OUT writes.
- **Clamp**: stored count 12 with MAX = 10 → only 10 neighbours are read, beta = 2457, latency 93.
- **Reset and restart**: assert rst_n low during vertex 2 of 3 → busy = 0 and WE = 0 immediately. Then restart → all three vertices are rewritten with correct values.

Source files
------------

// File: rtl/vertex_update.sv
// vertex_update: Loop even-vertex repositioning, reads OBJ/NBR RAMs and writes new positions to OUT RAM
module vertex_update #(
  parameter int MAX_NEIGHBOR_COUNT = 10,
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [31:0]           vertex_count,
  input  logic [31:0]           RAM_OBJ_Do,
  input  logic [31:0]           RAM_NBR_Do,
  output logic                  RAM_OBJ_EN,
  output logic                  RAM_NBR_EN,
  output logic                  RAM_OUT_EN,
  output logic [ADDR_WIDTH-1:0] RAM_OBJ_A,
  output logic [ADDR_WIDTH-1:0] RAM_NBR_A,
  output logic [ADDR_WIDTH-1:0] RAM_OUT_A,
  output logic [3:0]            RAM_OBJ_WE,
  output logic [3:0]            RAM_NBR_WE,
  output logic [3:0]            RAM_OUT_WE,
  output logic [31:0]           RAM_OBJ_Di,
  output logic [31:0]           RAM_NBR_Di,
  output logic [31:0]           RAM_OUT_Di,
  output logic                  busy
);
  localparam logic [3:0] IDLE = 4'd0, RD_CNT = 4'd1, RD_IDX = 4'd2, RD_NPOS = 4'd3, RD_SELF = 4'd4,
                         COMPUTE = 4'd5, WRITE = 4'd6, NEXT = 4'd7, DONE = 4'd8;
  localparam logic [3:0] MAXN = 4'(MAX_NEIGHBOR_COUNT);
  localparam logic [ADDR_WIDTH-1:0] A1 = 1, A2 = 2, A3 = 3, AMAX = ADDR_WIDTH'(MAX_NEIGHBOR_COUNT);
  localparam logic [15:0] BETA [16] = '{16'd0, 16'd0, 16'd8192, 16'd12288, 16'd6144, 16'd4915, 16'd4096, 16'd3510,
                                        16'd3072, 16'd2730, 16'd2457, 16'd2234, 16'd2048, 16'd1890, 16'd1755, 16'd1638};
  logic [3:0] state_q, state_d;
  logic ph_q, en_q;
  logic [1:0] ax_q;
  logic [3:0] nb_q, n_q, z_q, n_raw, n_clamp, nz;
  logic [31:0] count_q, v_q, idx_q;
  logic [ADDR_WIDTH-1:0] nbr_base_q, obj_base_q, out_base_q;
  logic signed [39:0] sum_q [3];
  logic [31:0] self_q [3], res_q [3], res [3];
  logic signed [39:0] diff [3];
  logic signed [47:0] prod [3];
  logic [15:0] beta;
  logic last_ax, rd_axis, rd;
  assign RAM_OBJ_EN = en_q;
  assign RAM_NBR_EN = en_q;
  assign RAM_OUT_EN = en_q;
  assign RAM_OBJ_WE = '0;
  assign RAM_NBR_WE = '0;
  assign RAM_OBJ_Di = '0;
  assign RAM_NBR_Di = '0;
  assign n_raw = RAM_NBR_Do[3:0];
  assign n_clamp = n_raw > MAXN ? MAXN : n_raw;
  assign last_ax = ax_q == 2'd2;
  assign rd_axis = state_q == RD_NPOS || state_q == RD_SELF;
  assign rd = rd_axis || state_q == RD_CNT || state_q == RD_IDX;
  assign beta = BETA[n_q];
  // zero-index neighbours stand in for self, so they simply drop out of n·self
  assign nz = n_q - z_q;
  for (genvar i = 0; i < 3; i++) begin : g_axis
    assign diff[i] = sum_q[i] - $signed({36'd0, nz}) * $signed({{8{self_q[i][31]}}, self_q[i]});
    assign prod[i] = 48'(diff[i]) * 48'($signed({1'b0, beta}));
    assign res[i] = self_q[i] + 32'(prod[i] >> 16);
  end
  // next-state sequencing of the per-vertex walk
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = vertex_count == 32'd0 ? DONE : RD_CNT;
      RD_CNT:  if (ph_q) state_d = n_clamp != 4'd0 ? RD_IDX : RD_SELF;
      RD_IDX:  if (ph_q) state_d = RD_NPOS;
      RD_NPOS: if (ph_q && last_ax) state_d = nb_q + 4'd1 == n_q ? RD_SELF : RD_IDX;
      RD_SELF: if (ph_q && last_ax) state_d = COMPUTE;
      COMPUTE: state_d = WRITE;
      WRITE:   if (last_ax) state_d = NEXT;
      NEXT:    state_d = v_q + 32'd1 == count_q ? DONE : RD_CNT;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // datapath and RAM port registers, all advancing on the falling edge
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ph_q <= 1'b0;
      ax_q <= 2'd0;
      nb_q <= 4'd0;
      n_q <= 4'd0;
      z_q <= 4'd0;
      count_q <= '0;
      v_q <= '0;
      idx_q <= '0;
      nbr_base_q <= '0;
      obj_base_q <= '0;
      out_base_q <= '0;
      sum_q <= '{3{40'sd0}};
      self_q <= '{3{32'd0}};
      res_q <= '{3{32'd0}};
      en_q <= 1'b0;
      busy <= 1'b0;
      RAM_OBJ_A <= '0;
      RAM_NBR_A <= '0;
      RAM_OUT_A <= '0;
      RAM_OUT_Di <= '0;
      RAM_OUT_WE <= '0;
    end else begin
      state_q <= state_d;
      ph_q <= rd ? ~ph_q : 1'b0;
      if ((rd_axis && ph_q) || state_q == WRITE) ax_q <= last_ax ? 2'd0 : ax_q + 2'd1;
      case (state_q)
        IDLE: if (start) begin
          busy <= 1'b1;
          en_q <= 1'b1;
          count_q <= vertex_count;
          v_q <= '0;
          nbr_base_q <= '0;
          obj_base_q <= A2;
          out_base_q <= '0;
        end
        RD_CNT: if (!ph_q) RAM_NBR_A <= nbr_base_q;
        else begin
          n_q <= n_clamp;
          nb_q <= 4'd0;
          z_q <= 4'd0;
          sum_q <= '{3{40'sd0}};
        end
        RD_IDX: if (!ph_q) RAM_NBR_A <= nbr_base_q + ADDR_WIDTH'(nb_q) + A1;
        else idx_q <= RAM_NBR_Do;
        RD_NPOS: if (!ph_q) begin
          if (idx_q != 32'd0) RAM_OBJ_A <= ADDR_WIDTH'(idx_q * 32'd3 + {30'd0, ax_q} - 32'd1);
        end else begin
          if (idx_q != 32'd0) sum_q[ax_q] <= sum_q[ax_q] + 40'($signed(RAM_OBJ_Do));
          else if (ax_q == 2'd0) z_q <= z_q + 4'd1;
          if (last_ax) nb_q <= nb_q + 4'd1;
        end
        RD_SELF: if (!ph_q) RAM_OBJ_A <= obj_base_q + ADDR_WIDTH'(ax_q);
        else self_q[ax_q] <= RAM_OBJ_Do;
        COMPUTE: res_q <= res;
        WRITE: begin
          RAM_OUT_A <= out_base_q + ADDR_WIDTH'(ax_q);
          RAM_OUT_Di <= res_q[ax_q];
          RAM_OUT_WE <= 4'hF;
        end
        NEXT: begin
          RAM_OUT_WE <= '0;
          v_q <= v_q + 32'd1;
          nbr_base_q <= nbr_base_q + AMAX;
          obj_base_q <= obj_base_q + A3;
          out_base_q <= out_base_q + A3;
        end
        DONE: begin
          busy <= 1'b0;
          en_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_vertex_update.sv
// tb_vertex_update: directed table, corner sequences and randomized passes against a Loop-rule model
module tb_vertex_update;
  localparam int MAX = 10;
  localparam int AW = 9;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, clr = 1'b0;
  logic [31:0] vertex_count = '0;
  logic [31:0] obj_do, nbr_do, out_di, obj_di, nbr_di;
  logic obj_en, nbr_en, out_en, busy;
  logic [AW-1:0] obj_a, nbr_a, out_a;
  logic [3:0] obj_we, nbr_we, out_we;
  logic [31:0] obj_mem [512], nbr_mem [512], out_mem [512];
  int wr_cnt;
  int checks = 0, failures = 0;
  int beta_t [16] = '{0, 0, 8192, 12288, 6144, 4915, 4096, 3510, 3072, 2730, 2457, 2234, 2048, 1890, 1755, 1638};
  typedef struct {
    int cnt;
    logic [31:0] sx, sy, sz, nx0, nstep, ex;
    int ecyc;
  } vec_t;
  vec_t tv [6];

  vertex_update #(.MAX_NEIGHBOR_COUNT(MAX), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .vertex_count(vertex_count),
    .RAM_OBJ_Do(obj_do), .RAM_NBR_Do(nbr_do),
    .RAM_OBJ_EN(obj_en), .RAM_NBR_EN(nbr_en), .RAM_OUT_EN(out_en),
    .RAM_OBJ_A(obj_a), .RAM_NBR_A(nbr_a), .RAM_OUT_A(out_a),
    .RAM_OBJ_WE(obj_we), .RAM_NBR_WE(nbr_we), .RAM_OUT_WE(out_we),
    .RAM_OBJ_Di(obj_di), .RAM_NBR_Di(nbr_di), .RAM_OUT_Di(out_di),
    .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (obj_en) obj_do <= obj_mem[obj_a];
    if (nbr_en) nbr_do <= nbr_mem[nbr_a];
    if (clr) begin
      for (int i = 0; i < 512; i++) out_mem[i] <= 32'hDEADBEEF;
      wr_cnt <= 0;
    end else if (out_en && out_we == 4'hF) begin
      out_mem[out_a] <= out_di;
      wr_cnt <= wr_cnt + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic int nbr_n(input int k);
    int n = int'(nbr_mem[k * MAX] & 32'hF);
    return n > MAX ? MAX : n;
  endfunction

  function automatic logic [31:0] ref_axis(input int k, input int c);
    int n, idx;
    longint s, self, d, p;
    n = nbr_n(k);
    self = longint'($signed(obj_mem[2 + 3 * k + c]));
    s = 0;
    for (int j = 0; j < n; j++) begin
      idx = int'(nbr_mem[k * MAX + 1 + j]);
      s += idx == 0 ? self : longint'($signed(obj_mem[2 + 3 * (idx - 1) + c]));
    end
    d = s - longint'(n) * self;
    p = d * longint'(beta_t[n]);
    return 32'(self + (p >>> 16));
  endfunction

  function automatic int ref_cycles(input int vc);
    int t = 1;
    for (int k = 0; k < vc; k++) t += 13 + 8 * nbr_n(k);
    return t;
  endfunction

  task automatic clear_mems();
    for (int i = 0; i < 512; i++) begin
      obj_mem[i] = '0;
      nbr_mem[i] = '0;
    end
  endtask

  task automatic setup_random(input int vc);
    int cnt, n;
    clear_mems();
    for (int k = 0; k < vc; k++) begin
      cnt = k == vc - 1 ? int'($urandom_range(0, 15)) : int'($urandom_range(0, MAX - 1));
      nbr_mem[k * MAX] = ($urandom_range(0, 255) << 4) | 32'(cnt);
      n = cnt > MAX ? MAX : cnt;
      for (int j = 0; j < n; j++)
        nbr_mem[k * MAX + 1 + j] = $urandom_range(0, 7) == 0 ? 32'd0 : $urandom_range(1, vc);
      for (int c = 0; c < 3; c++) obj_mem[2 + 3 * k + c] = $urandom;
    end
  endtask

  task automatic run_pass(input int vc, output int cyc);
    clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    start = 1'b1;
    vertex_count = 32'(vc);
    @(negedge clk);
    #1 start = 1'b0;
    chk("busy_rise", {31'd0, busy}, 32'd1);
    cyc = 1;
    while (busy === 1'b1 && cyc < 20000) begin
      @(negedge clk);
      #1 if (busy) cyc++;
    end
    chk("pass_timeout", {31'd0, cyc >= 20000}, 32'd0);
    chk("en_after_pass", {31'd0, out_en}, 32'd0);
    chk("we_after_pass", {28'd0, out_we}, 32'd0);
  endtask

  task automatic check_model(input string name, input int vc, input int cyc);
    chk({name, "_cycles"}, 32'(cyc), 32'(ref_cycles(vc)));
    chk({name, "_writes"}, 32'(wr_cnt), 32'(3 * vc));
    for (int k = 0; k < vc; k++)
      for (int c = 0; c < 3; c++) chk({name, "_out"}, out_mem[3 * k + c], ref_axis(k, c));
  endtask

  initial begin
    int cyc, vc, w0, t;
    tv[0] = '{4, 32'h00010000, 32'h11, 32'h22, 32'h00020000, 32'h0, 32'h00016000, 46};
    tv[1] = '{3, 32'h00000000, 32'h33, 32'h44, 32'h00010000, 32'h00010000, 32'h00012000, 38};
    tv[2] = '{6, 32'hFFFF0000, 32'h55, 32'h66, 32'h00000000, 32'h0, 32'hFFFF6000, 62};
    tv[3] = '{0, 32'd5, 32'd6, 32'd7, 32'h0, 32'h0, 32'd5, 14};
    tv[4] = '{12, 32'h00000000, 32'h77, 32'h88, 32'h00010000, 32'h0, 32'h00005FFA, 94};
    tv[5] = '{1, 32'h00010000, 32'h99, 32'hAA, 32'h00050000, 32'h0, 32'h00010000, 22};
    #22 rst_n = 1'b1;
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_en", {29'd0, obj_en, nbr_en, out_en}, 32'd0);
    chk("rst_we", {20'd0, obj_we, nbr_we, out_we}, 32'd0);
    chk("rst_addr", {5'd0, obj_a, nbr_a, out_a}, 32'd0);
    chk("rst_di", out_di | obj_di | nbr_di, 32'd0);

    for (int r = 0; r < 6; r++) begin
      clear_mems();
      nbr_mem[0] = 32'(tv[r].cnt);
      obj_mem[2] = tv[r].sx;
      obj_mem[3] = tv[r].sy;
      obj_mem[4] = tv[r].sz;
      for (int j = 0; j < tv[r].cnt; j++) begin
        nbr_mem[1 + j] = 32'(j + 2);
        obj_mem[5 + 3 * j] = j < MAX ? tv[r].nx0 + 32'(j) * tv[r].nstep : 32'h00700000;
        obj_mem[6 + 3 * j] = tv[r].sy;
        obj_mem[7 + 3 * j] = tv[r].sz;
      end
      run_pass(1, cyc);
      chk("vec_x", out_mem[0], tv[r].ex);
      chk("vec_y", out_mem[1], tv[r].sy);
      chk("vec_z", out_mem[2], tv[r].sz);
      chk("vec_cycles", 32'(cyc), 32'(tv[r].ecyc));
      chk("vec_writes", 32'(wr_cnt), 32'd3);
    end

    run_pass(0, cyc);
    chk("empty_cycles", 32'(cyc), 32'd1);
    chk("empty_writes", 32'(wr_cnt), 32'd0);

    clear_mems();
    nbr_mem[0] = 32'd3;
    nbr_mem[1] = 32'd2;
    nbr_mem[2] = 32'd0;
    nbr_mem[3] = 32'd3;
    obj_mem[2] = 32'h00010000;
    obj_mem[5] = 32'h00020000;
    obj_mem[8] = 32'h00020000;
    run_pass(1, cyc);
    chk("zero_idx_x", out_mem[0], 32'h00016000);
    chk("zero_idx_cycles", 32'(cyc), 32'd38);

    setup_random(3);
    clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    start = 1'b1;
    vertex_count = 32'd3;
    @(negedge clk);
    #1 start = 1'b0;
    t = 0;
    while (wr_cnt < 3 && t < 5000) begin
      @(negedge clk);
      t++;
    end
    chk("abort_timeout", {31'd0, t >= 5000}, 32'd0);
    repeat (4) @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_we", {28'd0, out_we}, 32'd0);
    chk("abort_en", {31'd0, out_en}, 32'd0);
    w0 = wr_cnt;
    repeat (5) @(negedge clk);
    chk("abort_no_writes", 32'(wr_cnt), 32'(w0));
    #2 rst_n = 1'b1;
    run_pass(3, cyc);
    check_model("restart", 3, cyc);

    for (int r = 0; r < 20; r++) begin
      vc = int'($urandom_range(2, 8));
      setup_random(vc);
      run_pass(vc, cyc);
      check_model("rand", vc, cyc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
